bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and output-enable sequencer for the shared 32-bit datapath bus. Up to `N_REQ` sources drive the bus through tri-state `BUFFER` instances. This block owns all of their `OE` lines. It guarantees that at most one enable is high in any cycle, bounds how long an owner may hold the bus while others wait, and optionally inserts a dead cycle between owners.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters/buffers. Legal range 2..16.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another requester is waiting. Legal range ≥ 1.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: reset. Asynchronous and active-low.
- `req`, input, `N_REQ`: level request per source. Bit i high means source i wants the bus.
- `oe`, output, `N_REQ`: one-hot-or-zero enable. Bit i connects to `OE` of buffer i. Registered.
- `owner`, output, `$clog2(N_REQ)`: index of current owner. Valid when `busy` is 1. Registered.
- `busy`, output, 1: high while any `oe` bit is high. Registered.
- `hold_cnt`, output, `$clog2(MAX_HOLD)+1`: cycles the current owner has held the bus, starting at 1 in the first grant cycle. Registered.

## Operation
- States: `IDLE`, `GRANT`, `TURN`. `TURN` exists only with the macro defined.
- `last` register holds the last owner index. Reset value is `N_REQ-1`, so source 0 wins the first arbitration.
- Pick rule: the first set `req` bit scanning `last+1, last+2, …` modulo `N_REQ`, with wrap-around.
- `IDLE`:
  - If `req` is nonzero, go to `GRANT` with the picked source.
  - Set `oe` = one-hot(pick), `owner` = pick, `last` = pick, `hold_cnt` = 1.
- `GRANT`: the owner is released when either:
  - (a) `req[owner]` = 0, or
  - (b) `hold_cnt` ≥ `MAX_HOLD` and some other `req` bit is set.
- If no release: `hold_cnt` increments and saturates at `MAX_HOLD`. There is no preemption while the owner is the only requester.
- On release:
  - With the macro defined: go to `TURN` with `oe` = 0.
  - Without the macro: re-arbitrate in the same edge, excluding the releasing owner in case (b). Load the new owner directly, or go to `IDLE` with `oe` = 0 if nothing remains.
- `TURN`: exactly one cycle with `oe` = 0, then behave as `IDLE` and arbitrate on current `req`.
- A released owner that re-requests waits its round-robin turn. It wins immediately only if it is the sole requester.
- `req` bits that change mid-grant only affect the next arbitration point.
- Invariant: `$countones(oe)` ≤ 1 in every cycle, including reset and all transitions.

## Timing
- Reset (async assert, any state): `oe` = 0, `busy` = 0, `owner` = 0, `hold_cnt` = 0, state = `IDLE`, `last` = `N_REQ-1`. Takes effect immediately, without waiting for a clock edge.
- Reset deassertion: the first arbitration happens at the first rising edge with `rst_n` = 1.
- Grant latency: `req` sampled high at edge k → `oe` high after edge k, visible in cycle k+1.
- Release latency: `req[owner]` sampled low at edge k → `oe[owner]` low after edge k.
- Handoff gap: 1 idle cycle with the macro, 0 cycles without it.

## Configuration
- Macro: `BUS_TURNAROUND_EN`.
- Defined: the `TURN` state is compiled in. There is one all-zero `oe` cycle between any two owners, including when the same source is re-granted after a case-(b) release. This gives break-before-make on the physical bus.
- Undefined: `TURN` and its transition logic are removed. Ownership switches in a single edge.
- The `oe`, `owner` and `busy` reset values are identical in both builds.

## Structure
- Package `bus_arb_pkg` holds:
  - the state enum (`IDLE`/`GRANT`/`TURN`);
  - width localparams derived from `N_REQ` and `MAX_HOLD`;
  - a function returning one-hot from an index.
- Sub-module `rr_pick`: purely combinational round-robin selector.
  - Inputs: `req`, `last`, `mask`.
  - Outputs: `valid`, `idx`.
  - Instantiated once by `bus_arbiter`. The FSM, counters and registers stay in the top.

## Test plan
Defaults (`N_REQ`=4, `MAX_HOLD`=8) unless stated.
1. Reset applied mid-`GRANT` with `req`=4'b0010 → `oe`=0, `busy`=0, `owner`=0 asynchronously. After release, source 0 requests first → `oe`=4'b0001 one cycle later.
2. `req`=4'b1111 held constant → `oe` rotates 0001→0010→0100→1000→0001, each grant lasting 8 cycles. With the macro there is 1 zero cycle between grants; without it, 0.
3. `req`=4'b0100 only, held 20 cycles → `oe`=4'b0100 for all 20 cycles and `hold_cnt` saturates at 8. Dropping `req` → `oe`=0 the next cycle.
4. Owner 1 drops `req` while `req[3]` and `req[0]` are pending → grant goes to 3 (round-robin from `last`=1), not 0.
5. Random `req` for 10k cycles, both builds → `$countones(oe)` ≤ 1 every cycle. Every `req` bit held continuously is granted within (`N_REQ`-1)·(`MAX_HOLD`+1)+1 cycles.
6. `N_REQ`=2, `MAX_HOLD`=1, `req`=2'b11 → `oe` alternates every grant cycle: 01,10,01,… without the macro; 01,00,10,00,… with it.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus arbiter. `BUS_TURNAROUND_EN adds the TURN state
// (one dead bus cycle between owners).
package bus_arb_pkg;

  localparam int unsigned MAX_REQ      = 16;
  localparam int unsigned DEF_N_REQ    = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;

`ifdef BUS_TURNAROUND_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} arb_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} arb_state_t;
`endif

  function automatic int unsigned idx_w(input int unsigned n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

  function automatic int unsigned hold_w(input int unsigned max_hold);
    return $clog2(max_hold) + 1;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
    logic [MAX_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first unmasked request after `last`, wrapping,
// with `last` itself scanned last.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] last,
  input  logic [N_REQ-1:0]        mask,
  output logic                    valid,
  output logic [idx_w(N_REQ)-1:0] idx
);

  localparam int unsigned IW = idx_w(N_REQ);

  logic [N_REQ-1:0] cand;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
    return IW'((32'(base) + off) % N_REQ);
  endfunction

  assign cand = req & ~mask;

  // Scan farthest-to-nearest so the nearest hit after `last` is the one that sticks.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      if (cand[wrap_idx(last, k)]) begin
        valid = 1'b1;
        idx   = wrap_idx(last, k);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter owning the OE lines of the shared-bus tri-state buffers.
// `BUS_TURNAROUND_EN inserts one all-zero oe cycle between any two owners.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           oe,
  output logic [idx_w(N_REQ)-1:0]    owner,
  output logic                       busy,
  output logic [hold_w(MAX_HOLD)-1:0] hold_cnt,
  output arb_state_t                 dbg_state
);

  localparam int unsigned IW = idx_w(N_REQ);
  localparam int unsigned HW = hold_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  arb_state_t       state;
  logic [IW-1:0]    last;
  logic [N_REQ-1:0] own_mask;
  logic [N_REQ-1:0] pick_mask;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             release_a;
  logic             release_b;

  assign own_mask  = N_REQ'(onehot(4'(owner)));
  assign pick_oh   = N_REQ'(onehot(4'(pick_idx)));
  // While granted, the owner is excluded so a forced release hands the bus onward.
  assign pick_mask = (state == GRANT) ? own_mask : '0;
  assign release_a = ~req[owner];
  assign release_b = (hold_cnt >= HOLD_MAX) && (|(req & ~own_mask));
  assign dbg_state = state;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .last  (last),
    .mask  (pick_mask),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= LAST_RST;
      owner    <= '0;
      oe       <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        GRANT: begin
          if (release_a || release_b) begin
`ifdef BUS_TURNAROUND_EN
            state    <= TURN;
            oe       <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
`else
            if (pick_valid) begin
              oe       <= pick_oh;
              owner    <= pick_idx;
              last     <= pick_idx;
              hold_cnt <= HW'(1);
            end else begin
              state    <= IDLE;
              oe       <= '0;
              busy     <= 1'b0;
              hold_cnt <= '0;
            end
`endif
          end else if (hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          // IDLE, and TURN after its single dead cycle, arbitrate on the current req.
          if (pick_valid) begin
            state    <= GRANT;
            oe       <= pick_oh;
            owner    <= pick_idx;
            last     <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= HW'(1);
          end else begin
            state    <= IDLE;
            oe       <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: scoreboard against a cycle model plus directed checks.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int SW = 11;
  localparam int STARVE_BOUND = (N - 1) * (MH + 1) + 1;
`ifdef BUS_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] oe;
  logic [1:0] owner;
  logic       busy;
  logic [3:0] hold_cnt;
  arb_state_t dbg_state;

  logic [1:0] req2;
  logic [1:0] oe2;
  logic       owner2;
  logic       busy2;
  logic       hold2;
  arb_state_t dbg_state2;

  int total = 0;
  int bad   = 0;

  logic [SW-1:0] exp_q[$];

  // cycle model state
  int         m_state;
  int         m_last;
  int         m_owner;
  int         m_hold;
  logic [3:0] m_oe;
  logic       m_busy;

  int         wait_cnt[4];
  int         max_wait;
  logic [3:0] last_g;
  int         run_len;
  int         gap_len;
  logic [3:0] rnd_req;
  int         rnd_len;
  logic [1:0] exp6[6];

  // clock / reset
  always #5 clk = ~clk;

  bus_arbiter #(.N_REQ(4), .MAX_HOLD(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .oe        (oe),
    .owner     (owner),
    .busy      (busy),
    .hold_cnt  (hold_cnt),
    .dbg_state (dbg_state)
  );

  bus_arbiter #(.N_REQ(2), .MAX_HOLD(1)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req2),
    .oe        (oe2),
    .owner     (owner2),
    .busy      (busy2),
    .hold_cnt  (hold2),
    .dbg_state (dbg_state2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("onehot_oe", 32'($countones(oe) <= 1), 32'd1);
    check("onehot_oe2", 32'($countones(oe2) <= 1), 32'd1);
  end

  // reference model
  function automatic int rr_next(input logic [3:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[2'((from + k) % N)]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_last  = N - 1;
    m_owner = 0;
    m_hold  = 0;
    m_oe    = 4'b0;
    m_busy  = 1'b0;
  endtask

  task automatic model_load(input int p);
    if (p >= 0) begin
      m_state = 1;
      m_owner = p;
      m_last  = p;
      m_oe    = 4'b0001 << p;
      m_busy  = 1'b1;
      m_hold  = 1;
    end else begin
      m_state = 0;
      m_oe    = 4'b0;
      m_busy  = 1'b0;
      m_hold  = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] r);
    logic [3:0] others;
    others = r & ~(4'b0001 << m_owner);
    if (m_state == 1) begin
      if (!r[2'(m_owner)] || (m_hold >= MH && others != 4'b0)) begin
        if (TURN_EN) begin
          m_state = 2;
          m_oe    = 4'b0;
          m_busy  = 1'b0;
          m_hold  = 0;
        end else begin
          model_load(rr_next(others, m_last));
        end
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end else begin
      model_load(rr_next(r, m_last));
    end
  endtask

  // driver: called at a negedge, returns at the next negedge after checking
  task automatic step(input logic [3:0] r);
    logic [SW-1:0] e;
    req = r;
    @(posedge clk);
    model_edge(r);
    exp_q.push_back({m_oe, 2'(m_owner), m_busy, 4'(m_hold)});
    @(negedge clk);
    e = exp_q.pop_front();
    check("sb_oe", 32'(oe), 32'(e[10:7]));
    check("sb_busy", 32'(busy), 32'(e[4]));
    check("sb_hold", 32'(hold_cnt), 32'(e[3:0]));
    if (e[4]) check("sb_owner", 32'(owner), 32'(e[6:5]));
    for (int i = 0; i < N; i++) begin
      if (r[i] && !oe[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0;
    req2  = 2'b0;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0;
    req2  = 2'b0;
    max_wait = 0;
    model_reset();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    if (TURN_EN) exp6 = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    else         exp6 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    repeat (2) @(negedge clk);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_hold", 32'(hold_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // 1: asynchronous reset in the middle of a grant to source 1
    repeat (3) step(4'b0010);
    check("t1_pre_owner", 32'(owner), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_oe", 32'(oe), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    check("t1_async_owner", 32'(owner), 32'd0);
    model_reset();
    exp_q.delete();
    req = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001);
    check("t1_first_oe", 32'(oe), 32'b0001);

    // 2: all requesting, fair rotation with 8-cycle grants
    apply_reset();
    last_g  = 4'b0;
    run_len = 0;
    gap_len = 0;
    for (int c = 0; c < 70; c++) begin
      step(4'b1111);
      if (oe == 4'b0) begin
        gap_len++;
      end else if (oe == last_g) begin
        run_len++;
      end else begin
        if (last_g != 4'b0) begin
          check("t2_len", 32'(run_len), 32'(MH));
          check("t2_rot", 32'(oe), 32'({last_g[2:0], last_g[3]}));
          check("t2_gap", 32'(gap_len), 32'(TURN_EN));
        end
        last_g  = oe;
        run_len = 1;
        gap_len = 0;
      end
    end

    // 3: sole requester is never preempted, hold saturates
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      step(4'b0100);
      check("t3_oe", 32'(oe), 32'b0100);
    end
    check("t3_hold_sat", 32'(hold_cnt), 32'(MH));
    step(4'b0000);
    check("t3_drop_oe", 32'(oe), 32'd0);

    // 4: release by owner 1 goes to 3, not 0
    apply_reset();
    step(4'b0001);
    step(4'b0010);
    if (TURN_EN) step(4'b0010);
    check("t4_owner1", 32'(owner), 32'd1);
    repeat (2) step(4'b1011);
    step(4'b1001);
    if (TURN_EN) step(4'b1001);
    check("t4_next_oe", 32'(oe), 32'b1000);
    check("t4_next_owner", 32'(owner), 32'd3);

    // 5: random request patterns
    apply_reset();
    max_wait = 0;
    for (int p = 0; p < 1500; p++) begin
      rnd_req = 4'($urandom_range(0, 15));
      rnd_len = $urandom_range(1, 12);
      for (int c = 0; c < rnd_len; c++) step(rnd_req);
    end
    check("t5_starve", 32'(max_wait <= STARVE_BOUND), 32'd1);

    // 6: N_REQ=2, MAX_HOLD=1 alternates every grant cycle
    apply_reset();
    req2 = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("t6_oe2", 32'(oe2), 32'(exp6[c]));
    end
    req2 = 2'b00;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
